// File: rtl/poly_mm_pkg.sv
// poly_mm_pkg: moduli presets, LFSR taps and the stage payload shared by the modular multiplier
package poly_mm_pkg;

    localparam int MM_W     = 24;
    localparam int MM_TAG_W = 8;

    localparam logic [MM_W-1:0] Q_DILITHIUM = 24'd8380417;
    localparam logic [MM_W:0]   M_DILITHIUM = 25'd8396807;
    localparam logic [4:0]      N_DILITHIUM = 5'd23;
    localparam logic [MM_W-1:0] Q_KYBER     = 24'd3329;
    localparam logic [MM_W:0]   M_KYBER     = 25'd5039;
    localparam logic [4:0]      N_KYBER     = 5'd12;

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef struct packed {
        logic                valid;
        logic [MM_TAG_W-1:0] tag;
        logic [2*MM_W-1:0]   p;
        logic [MM_W+1:0]     t;
        logic                flag;
    } stage_t;

endpackage

// File: rtl/poly_mm_lfsr.sv
// poly_mm_lfsr: seeded 32-bit Galois LFSR with advance enable and recovery from the all-zero state
module poly_mm_lfsr
    import poly_mm_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2357
) (
    input  logic        poly_mm_clk,
    input  logic        poly_mm_rst_n,
    input  logic        en,
    output logic [31:0] state
);

    // step on enable; the zero state is a fixed point, so it is replaced by the seed
    always_ff @(posedge poly_mm_clk or negedge poly_mm_rst_n)
        if (!poly_mm_rst_n)
            state <= SEED;
        else if (state == '0)
            state <= SEED;
        else if (en)
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);

endmodule

// File: rtl/poly_modmul_pipe_masked.sv
// poly_modmul_pipe_masked: 4-stage Barrett modular multiplier emitting two arithmetic shares
// Define POLY_MM_BLIND_EN to enable operand/result blinding with a random sign flip.
module poly_modmul_pipe_masked
    import poly_mm_pkg::*;
#(
    parameter int          W         = 24,
    parameter int          TAG_W     = 8,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2357
) (
    input  logic             poly_mm_clk,
    input  logic             poly_mm_rst_n,
    input  logic [W-1:0]     cfg_q,
    input  logic [W:0]       cfg_m,
    input  logic [4:0]       cfg_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_share1,
    output logic [W-1:0]     out_share2,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PW = 2 * MM_W;
    localparam int TW = MM_W + 2;

    stage_t          s1, s2, s3;
    logic [31:0]     lfsr;
    logic            stall, load4, flag1, pipe_unused;
    logic [W-1:0]    a_eff, res, res_b, mraw, mask, share1;
    logic [2*W-1:0]  u;
    logic [3*W+1:0]  um;
    logic [W+1:0]    t2, r3, q2, r1;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign load4    = ~stall & s3.valid;
    assign busy     = s1.valid | s2.valid | s3.valid | out_valid;
    assign q2       = (W+2)'(cfg_q);

`ifdef POLY_MM_BLIND_EN
    assign flag1 = lfsr[31];
    assign a_eff = (flag1 && in_a != '0) ? cfg_q - in_a : in_a;
    assign res_b = (s3.flag && res != '0) ? cfg_q - res : res;
`else
    assign flag1 = 1'b0;
    assign a_eff = in_a;
    assign res_b = res;
`endif

    // Barrett quotient estimate; widened so N = W cannot overflow the product
    assign u  = s1.p[2*W-1:0] >> (cfg_n - 5'd1);
    assign um = (3*W+2)'(u) * (3*W+2)'(cfg_m);
    assign t2 = (W+2)'(um >> (cfg_n + 5'd1));

    // the true remainder is below 3q < 2^(W+2), so W+2 low bits of the difference are exact
    assign r3  = s2.p[W+1:0] - s2.t[W+1:0] * q2;
    assign r1  = s3.p[W+1:0] >= q2 ? s3.p[W+1:0] - q2 : s3.p[W+1:0];
    assign res = W'(r1 >= q2 ? r1 - q2 : r1);

    assign mraw   = lfsr[W-1:0] & W'(((W+1)'(1) << cfg_n) - (W+1)'(1));
    assign mask   = mraw >= cfg_q ? mraw - cfg_q : mraw;
    assign share1 = res_b >= mask ? res_b - mask : res_b + cfg_q - mask;

    assign pipe_unused = ^{s1.t, s2.p[PW-1:W+2], s3.p[PW-1:W+2], s3.t, s3.flag, lfsr[31:W]};

    poly_mm_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .poly_mm_clk   (poly_mm_clk),
        .poly_mm_rst_n (poly_mm_rst_n),
        .en            (load4),
        .state         (lfsr)
    );

    // internal stages S1..S3 advance together unless the output is stalled
    always_ff @(posedge poly_mm_clk or negedge poly_mm_rst_n)
        if (!poly_mm_rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else if (!stall) begin
            s1 <= '{valid: in_valid, tag: MM_TAG_W'(in_tag),
                    p: PW'(PW'(a_eff) * PW'(in_b)), t: '0, flag: flag1};
            s2 <= '{valid: s1.valid, tag: s1.tag, p: s1.p, t: TW'(t2), flag: s1.flag};
            s3 <= '{valid: s2.valid, tag: s2.tag, p: PW'(r3), t: '0, flag: s2.flag};
        end

    // S4: final reduction and masking; registers hold while the consumer stalls
    always_ff @(posedge poly_mm_clk or negedge poly_mm_rst_n)
        if (!poly_mm_rst_n) begin
            out_valid  <= 1'b0;
            out_share1 <= '0;
            out_share2 <= '0;
            out_tag    <= '0;
        end else if (!stall) begin
            out_valid <= s3.valid;
            if (s3.valid) begin
                out_share1 <= share1;
                out_share2 <= mask;
                out_tag    <= TAG_W'(s3.tag);
            end
        end

endmodule

// File: tb/tb_poly_modmul_pipe_masked.sv
// tb_poly_modmul_pipe_masked: randomized self-checking bench against a (a*b) mod q scoreboard
module tb_poly_modmul_pipe_masked;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  cfg_q;
    logic [W:0]    cfg_m;
    logic [4:0]    cfg_n;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  in_a, in_b, out_share1, out_share2;
    logic [7:0]    in_tag, out_tag;

    typedef struct {
        logic [7:0] tag;
        longint     val;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  s2_seen[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic          prev_stall = 1'b0;
    logic [55:0]   prev_out;

    poly_modmul_pipe_masked dut (
        .poly_mm_clk   (clk),
        .poly_mm_rst_n (rst_n),
        .cfg_q         (cfg_q),
        .cfg_m         (cfg_m),
        .cfg_n         (cfg_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_share1    (out_share1),
        .out_share2    (out_share2),
        .out_tag       (out_tag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // scoreboard: handshakes seen at the negedge are the ones taken at the next posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_stall <= 1'b0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall)
                check("hold", {out_valid, out_share1, out_share2, out_tag} == {1'b1, prev_out}, 1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("tag", out_tag, e.tag);
                    check("sum", (longint'(out_share1) + longint'(out_share2)) % longint'(cfg_q), e.val);
                    check("s1_lt_q", out_share1 < cfg_q, 1);
                    check("s2_lt_q", out_share2 < cfg_q, 1);
                end
                s2_seen.push_back(out_share2);
            end
            if (in_valid && in_ready)
                sb.push_back('{in_tag, (longint'(in_a) * longint'(in_b)) % longint'(cfg_q)});
            prev_stall <= out_valid && !out_ready;
            prev_out   <= {out_share1, out_share2, out_tag};
        end
    end

    task automatic set_cfg(input logic [W-1:0] q, input logic [W:0] m, input logic [4:0] n);
        cfg_q = q;
        cfg_m = m;
        cfg_n = n;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] t);
        int k = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        @(negedge clk);
        while (!in_ready && k < 64) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", busy, 0);
    endtask

    function automatic logic [W-1:0] pick();
        int unsigned r = $urandom_range(9);
        if (r == 0) return '0;
        if (r == 1) return cfg_q - 1'b1;
        return W'($urandom_range(32'(cfg_q) - 1));
    endfunction

    task automatic rand_run(input int n);
        int   sent = 0;
        int   cyc = 0;
        logic hs;
        while (sent < n && cyc < 8 * n) begin
            if (!in_valid && $urandom_range(7) != 0) begin
                in_valid = 1'b1;
                in_a = pick();
                in_b = pick();
                in_tag = 8'($urandom);
            end
            out_ready = $urandom_range(3) != 0;
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                in_valid = 1'b0;
                sent++;
            end
            cyc++;
        end
        check("rand_done", sent, n);
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        int early, acc, diff;
        logic [7:0] nt;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        out_ready = 1'b1;
        set_cfg(poly_mm_pkg::Q_DILITHIUM, poly_mm_pkg::M_DILITHIUM, poly_mm_pkg::N_DILITHIUM);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_share1", out_share1, 0);
        check("rst_share2", out_share2, 0);
        check("rst_tag", out_tag, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: largest Dilithium operands and exact latency
        send(poly_mm_pkg::Q_DILITHIUM - 1, poly_mm_pkg::Q_DILITHIUM - 1, 8'd1);
        early = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) early++;
        end
        check("lat_early", early, 0);
        @(negedge clk);
        check("lat4", out_valid, 1);
        check("t1_prod", (longint'(out_share1) + longint'(out_share2)) % longint'(poly_mm_pkg::Q_DILITHIUM), 1);
        drain();

        // T2: Kyber corner values
        set_cfg(poly_mm_pkg::Q_KYBER, poly_mm_pkg::M_KYBER, poly_mm_pkg::N_KYBER);
        send(3328, 3328, 8'd2);
        send(2, 3, 8'd3);
        send(0, 1234, 8'd4);
        drain();

        // T3: backpressure with in_valid held
        out_ready = 1'b0;
        nt = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_a = W'(nt) + 1'b1;
            in_b = W'(nt) + 2'd2;
            in_tag = nt;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            if (acc > int'(nt)) nt++;
        end
        in_valid = 1'b0;
        check("t3_accepted", acc, 4);
        out_ready = 1'b1;
        while (nt < 6) begin
            send(W'(nt) + 1'b1, W'(nt) + 2'd2, nt);
            nt++;
        end
        drain();
        check("t3_empty", sb.size(), 0);

        // T4: identical back-to-back ops get different masks
        s2_seen.delete();
        repeat (16) send(1234, 567, 8'd9);
        drain();
        check("t4_count", s2_seen.size(), 16);
        diff = 0;
        foreach (s2_seen[i]) if (s2_seen[i] != s2_seen[0]) diff = 1;
        check("s2_varies", diff, 1);

        // T5: reset with work in flight
        send(11, 12, 8'h10);
        send(13, 14, 8'h11);
        send(15, 16, 8'h12);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        send(5, 7, 8'hAA);
        early = 0;
        while (!out_valid && early < 20) begin
            @(negedge clk);
            early++;
        end
        check("t5_first_tag", out_tag, 8'hAA);
        drain();

        // T6: random traffic on both moduli
        rand_run(10000);
        set_cfg(poly_mm_pkg::Q_DILITHIUM, poly_mm_pkg::M_DILITHIUM, poly_mm_pkg::N_DILITHIUM);
        rand_run(10000);
        check("final_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
